test_din_sink: RTL and testbench
================================

// Module: test_din_sink
// PURPOSE
//  Valid-qualified input-stream sink and checker for a DWIDTH-bit data bus.
//  Every beat (din_valid=1) is counted, summed into a checksum and compared against an incrementing reference sequence.
//  Mismatches are counted, and the first one is captured.
//  Sits at the end of a data path under test; its status outputs feed debug/CSR logic.
// PARAMETERS
//  DWIDTH     16  width of din_data and of the reference/checksum/capture registers
//  CNT_WIDTH  32  width of beat and error counters
// PORTS
//  clk            in   1          single clock; all logic on rising edge
//  rst_n          in   1          reset, synchronous, active-low
//  din_valid      in   1          beat qualifier; din_data sampled only when 1
//  din_data       in   DWIDTH     input data word
//  beat_cnt       out  CNT_WIDTH  number of accepted beats, saturating
//  err_cnt        out  CNT_WIDTH  number of mismatching beats, saturating
//  err_flag       out  1          sticky: at least one mismatch since reset
//  checksum       out  DWIDTH     sum of all accepted din_data, mod 2^DWIDTH
//  last_data      out  DWIDTH     most recent accepted din_data
//  first_err_exp  out  DWIDTH     expected value at first mismatch
//  first_err_got  out  DWIDTH     received value at first mismatch
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge):
//    - all outputs and internal expected-value register (exp) cleared to 0; exp=0 means the first beat must be 0.
//    - Reset wins over a simultaneous beat; a beat in the reset cycle is dropped.
//  - Beat = din_valid=1 at a rising edge with rst_n=1. din_valid=0 cycles: no state change, no timeout.
//  - Latency: all outputs are registered and reflect a beat on the cycle after it.
//  - Match (din_data==exp): exp <= din_data+1 mod 2^DWIDTH. Wrap: after 2^DWIDTH-1, 0 is expected.
//  - Mismatch:
//    - err_cnt++ and err_flag<=1.
//    - if err_flag was 0 (first mismatch): first_err_exp<=exp, first_err_got<=din_data; never overwritten later.
//    - Resync: exp <= din_data+1, so one corrupted word counts one error, not a cascade.
//  - Every beat, match or not: beat_cnt++; checksum <= checksum+din_data, truncated to DWIDTH; last_data <= din_data.
//  - Counters saturate at all-ones, no wrap; err_flag stays 1 even when err_cnt saturates.
//  - No X propagation: din_data is ignored when din_valid=0.
//  - Mid-stream reset: everything returns to reset values; the next beat is checked against 0.
// STRUCTURE
//  - Package test_din_pkg: default DWIDTH/CNT_WIDTH localparams, function sat_inc(), and a typedef for the error-capture record {exp, got}.
//  - Sub-module test_din_sat_cnt: CNT_WIDTH saturating counter with sync active-low reset and an inc enable.
//    Instantiated twice (beats, errors).
//  - Top: exp register, compare logic, checksum accumulator, capture registers.
// TESTING
//  1. Hold rst_n=0 for 2 clocks, then release -> all outputs 0, err_flag=0.
//  2. Beats 0..9 with gaps of din_valid=0 -> beat_cnt=10, err_cnt=0, checksum=45, last_data=9.
//  3. Beats 0,1,2,7,8,9 -> err_cnt=1, first_err_exp=3, first_err_got=7, beat_cnt=6, no further errors.
//  4. Wrap: beats 0..65535 then 0 (DWIDTH=16) -> err_cnt=0, beat_cnt=65537, checksum=0x8000.
//  5. Mid-stream: beats 0,1,2; reset 1 cycle with din_valid=1 and din_data=3 during reset;
//     then beats 0,1 -> beat_cnt=2, checksum=1, err_cnt=0.
//  6. Saturation (CNT_WIDTH=4): 20 mismatching beats (all 0x5555) -> err_cnt=15, beat_cnt=15, err_flag=1,
//     first_err_exp=0, first_err_got=0x5555.

Source files
------------

// File: rtl/test_din_pkg.sv
// Shared defaults, the saturating-increment helper and the first-error capture record
// for the test_din stream sink.
package test_din_pkg;

  localparam int DWIDTH_DEF    = 16;
  localparam int CNT_WIDTH_DEF = 32;

  // Callers widen to 64 bits and size-cast the result back, so one helper serves every counter width.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max);
    return (v >= max) ? max : v + 64'd1;
  endfunction

  typedef struct packed {
    logic [DWIDTH_DEF-1:0] exp;
    logic [DWIDTH_DEF-1:0] got;
  } err_rec_t;

endpackage

// File: rtl/test_din_sat_cnt.sv
// Saturating up-counter with synchronous active-low clear and increment enable.
module test_din_sat_cnt
  import test_din_pkg::*;
#(
  parameter int W = CNT_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc) cnt_d = W'(sat_inc(64'(cnt_q), 64'(MAX)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/test_din_sink.sv
// Stream sink: checks beats against an incrementing sequence, counts beats and errors,
// accumulates a checksum and captures the first mismatch.
module test_din_sink
  import test_din_pkg::*;
#(
  parameter int DWIDTH    = DWIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din_valid,
  input  logic [DWIDTH-1:0]    din_data,
  output logic [CNT_WIDTH-1:0] beat_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic                 err_flag,
  output logic [DWIDTH-1:0]    checksum,
  output logic [DWIDTH-1:0]    last_data,
  output logic [DWIDTH-1:0]    first_err_exp,
  output logic [DWIDTH-1:0]    first_err_got
);

  logic [DWIDTH-1:0] exp_q, exp_d;
  logic [DWIDTH-1:0] checksum_q, checksum_d;
  logic [DWIDTH-1:0] last_q, last_d;
  logic              err_flag_q, err_flag_d;
  err_rec_t          cap_q, cap_d;
  logic              mismatch;

  assign mismatch = din_valid && (din_data != exp_q);

  always_comb begin
    exp_d      = exp_q;
    checksum_d = checksum_q;
    last_d     = last_q;
    err_flag_d = err_flag_q;
    cap_d      = cap_q;
    if (din_valid) begin
      // Match or not, the next word is expected to follow the received one (resync).
      exp_d      = din_data + DWIDTH'(1);
      checksum_d = checksum_q + din_data;
      last_d     = din_data;
      if (mismatch) begin
        err_flag_d = 1'b1;
        if (!err_flag_q) begin
          cap_d.exp = exp_q;
          cap_d.got = din_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_q      <= '0;
      checksum_q <= '0;
      last_q     <= '0;
      err_flag_q <= 1'b0;
      cap_q      <= '0;
    end else begin
      exp_q      <= exp_d;
      checksum_q <= checksum_d;
      last_q     <= last_d;
      err_flag_q <= err_flag_d;
      cap_q      <= cap_d;
    end
  end

  test_din_sat_cnt #(.W(CNT_WIDTH)) u_beat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (din_valid),
    .cnt   (beat_cnt)
  );

  test_din_sat_cnt #(.W(CNT_WIDTH)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mismatch),
    .cnt   (err_cnt)
  );

  assign err_flag      = err_flag_q;
  assign checksum      = checksum_q;
  assign last_data     = last_q;
  assign first_err_exp = cap_q.exp;
  assign first_err_got = cap_q.got;

endmodule

// File: tb/tb_test_din_sink.sv
// Bench for test_din_sink: directed scenarios plus random traffic against a behavioural model,
// and a second narrow-counter instance for saturation.
module tb_test_din_sink;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, default widths.
  logic        rst_n;
  logic        din_valid;
  logic [15:0] din_data;
  logic [31:0] beat_cnt, err_cnt;
  logic        err_flag;
  logic [15:0] checksum, last_data, first_err_exp, first_err_got;

  test_din_sink u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .din_valid     (din_valid),
    .din_data      (din_data),
    .beat_cnt      (beat_cnt),
    .err_cnt       (err_cnt),
    .err_flag      (err_flag),
    .checksum      (checksum),
    .last_data     (last_data),
    .first_err_exp (first_err_exp),
    .first_err_got (first_err_got)
  );

  // Saturation instance, 4-bit counters.
  logic        s_rst_n;
  logic        s_valid;
  logic [15:0] s_data;
  logic [3:0]  s_beat_cnt, s_err_cnt;
  logic        s_err_flag;
  logic [15:0] s_checksum, s_last_data, s_first_err_exp, s_first_err_got;

  test_din_sink #(.DWIDTH(16), .CNT_WIDTH(4)) u_sat (
    .clk           (clk),
    .rst_n         (s_rst_n),
    .din_valid     (s_valid),
    .din_data      (s_data),
    .beat_cnt      (s_beat_cnt),
    .err_cnt       (s_err_cnt),
    .err_flag      (s_err_flag),
    .checksum      (s_checksum),
    .last_data     (s_last_data),
    .first_err_exp (s_first_err_exp),
    .first_err_got (s_first_err_got)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural reference: unbounded counts and sum, reduced only when compared.
  longint      m_beats, m_errs, m_sum;
  logic [15:0] m_exp, m_last, m_cexp, m_cgot;
  logic        m_flag;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sat32(input longint v);
    return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : 64'(v);
  endfunction

  task automatic model_reset();
    m_beats = 0; m_errs = 0; m_sum = 0;
    m_exp = '0; m_last = '0; m_cexp = '0; m_cgot = '0; m_flag = 1'b0;
  endtask

  // Drive one cycle on the main instance from a negedge; the model follows the same rules.
  task automatic step(input logic v, input logic [15:0] d);
    din_valid = v;
    din_data  = d;
    @(negedge clk);
    if (!rst_n) model_reset();
    else if (v) begin
      m_beats++;
      if (d != m_exp) begin
        if (!m_flag) begin
          m_cexp = m_exp;
          m_cgot = d;
        end
        m_flag = 1'b1;
        m_errs++;
      end
      m_exp  = d + 16'd1;
      m_sum  = m_sum + longint'(d);
      m_last = d;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 16'h0);
    rst_n = 1'b1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".beat_cnt"},  64'(beat_cnt),      sat32(m_beats));
    chk({tag, ".err_cnt"},   64'(err_cnt),       sat32(m_errs));
    chk({tag, ".err_flag"},  64'(err_flag),      64'(m_flag));
    chk({tag, ".checksum"},  64'(checksum),      64'(m_sum % 65536));
    chk({tag, ".last_data"}, 64'(last_data),     64'(m_last));
    chk({tag, ".fe_exp"},    64'(first_err_exp), 64'(m_cexp));
    chk({tag, ".fe_got"},    64'(first_err_got), 64'(m_cgot));
  endtask

  initial begin
    rst_n = 1'b0; din_valid = 1'b0; din_data = '0;
    s_rst_n = 1'b0; s_valid = 1'b0; s_data = '0;
    model_reset();
    @(negedge clk);

    // 1. Reset held two clocks, with a beat offered during reset.
    step(1'b1, 16'h1234);
    step(1'b0, 16'h0);
    rst_n = 1'b1;
    check_all("reset");
    chk("reset.const_beat", 64'(beat_cnt), 64'd0);
    chk("reset.const_flag", 64'(err_flag), 64'd0);
    chk("reset.sat_beat",   64'(s_beat_cnt), 64'd0);
    chk("reset.sat_flag",   64'(s_err_flag), 64'd0);

    // 2. Beats 0..9 with idle gaps carrying junk data.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 16'(i));
      if (i % 2 == 1) step(1'b0, 16'($urandom));
    end
    check_all("seq10");
    chk("seq10.beat", 64'(beat_cnt), 64'd10);
    chk("seq10.sum",  64'(checksum), 64'd45);
    chk("seq10.last", 64'(last_data), 64'd9);
    chk("seq10.err",  64'(err_cnt),  64'd0);

    // 3. One skip in the sequence counts exactly one error.
    do_reset();
    step(1'b1, 16'd0); step(1'b1, 16'd1); step(1'b1, 16'd2);
    step(1'b1, 16'd7);
    chk("skip.lat_err", 64'(err_cnt), 64'd1);
    step(1'b1, 16'd8); step(1'b1, 16'd9);
    check_all("skip");
    chk("skip.err",  64'(err_cnt),       64'd1);
    chk("skip.fexp", 64'(first_err_exp), 64'd3);
    chk("skip.fgot", 64'(first_err_got), 64'd7);
    chk("skip.beat", 64'(beat_cnt),      64'd6);

    // 4. Full 16-bit wrap then 0.
    do_reset();
    for (int i = 0; i < 65536; i++) step(1'b1, 16'(i));
    step(1'b1, 16'd0);
    check_all("wrap");
    chk("wrap.beat", 64'(beat_cnt), 64'd65537);
    chk("wrap.err",  64'(err_cnt),  64'd0);
    chk("wrap.sum",  64'(checksum), 64'h8000);

    // 5. Mid-stream reset drops the beat presented during it.
    do_reset();
    step(1'b1, 16'd0); step(1'b1, 16'd1); step(1'b1, 16'd2);
    rst_n = 1'b0;
    step(1'b1, 16'd3);
    rst_n = 1'b1;
    step(1'b1, 16'd0); step(1'b1, 16'd1);
    check_all("midrst");
    chk("midrst.beat", 64'(beat_cnt), 64'd2);
    chk("midrst.sum",  64'(checksum), 64'd1);
    chk("midrst.err",  64'(err_cnt),  64'd0);

    // Random traffic: mostly in-sequence words, occasional corruption, random idles.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic        v;
      logic [15:0] d;
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 9) == 0) ? 16'($urandom) : m_exp;
      step(v, d);
      if (i % 50 == 49) check_all("rand");
    end

    // 6. Saturation on the 4-bit instance.
    s_rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1;
      s_data  = 16'h5555;
      @(negedge clk);
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk("sat.err",  64'(s_err_cnt),       64'd15);
    chk("sat.beat", 64'(s_beat_cnt),      64'd15);
    chk("sat.flag", 64'(s_err_flag),      64'd1);
    chk("sat.fexp", 64'(s_first_err_exp), 64'd0);
    chk("sat.fgot", 64'(s_first_err_got), 64'h5555);
    chk("sat.last", 64'(s_last_data),     64'h5555);
    chk("sat.sum",  64'(s_checksum),      64'((20 * 32'h5555) % 65536));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
